// File: rtl/mycpu_pkg.sv
// mycpu shared definitions: function-select encoding, PC/write-back select
// codes and the packed control word consumed by the datapath.
package mycpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    FS_A     = 4'b0000,
    FS_INC   = 4'b0001,
    FS_ADD   = 4'b0010,
    FS_ADDC  = 4'b0011,
    FS_ADDNB = 4'b0100,
    FS_SUB   = 4'b0101,
    FS_DEC   = 4'b0110,
    FS_RSV7  = 4'b0111,
    FS_AND   = 4'b1000,
    FS_OR    = 4'b1001,
    FS_XOR   = 4'b1010,
    FS_NOT   = 4'b1011,
    FS_B     = 4'b1100,
    FS_SHR   = 4'b1101,
    FS_SHL   = 4'b1110,
    FS_RSVF  = 4'b1111
  } fs_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  localparam logic [1:0] MD_F    = 2'b00;
  localparam logic [1:0] MD_B    = 2'b01;
  localparam logic [1:0] MD_IO   = 2'b10;
  localparam logic [1:0] MD_MEM  = 2'b11;

  typedef struct packed {
    logic        il;
    logic [1:0]  ps;
    logic        rw;
    logic [11:0] rs;
    logic        mm;
    logic [1:0]  md;
    logic        mb;
    fs_t         fs;
    logic        wen;
    logic        iom;
  } ctrl_word_t;

endpackage

// File: rtl/dp_fu.sv
// mycpu function unit: purely combinational 16-bit ALU/shifter with
// zero and negative indications of its result. Carries are discarded.
module dp_fu
  import mycpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  fs_t               fs,
  output logic [DATA_W-1:0] f,
  output logic              z,
  output logic              n
);

  // Operation select; unused codes pass A through
  always_comb begin
    f = a;
    case (fs)
      FS_A:     f = a;
      FS_INC:   f = a + 16'd1;
      FS_ADD:   f = a + b;
      FS_ADDC:  f = a + b + 16'd1;
      FS_ADDNB: f = a + ~b;
      FS_SUB:   f = a - b;
      FS_DEC:   f = a - 16'd1;
      FS_AND:   f = a & b;
      FS_OR:    f = a | b;
      FS_XOR:   f = a ^ b;
      FS_NOT:   f = ~a;
      FS_B:     f = b;
      FS_SHR:   f = {1'b0, b[DATA_W-1:1]};
      FS_SHL:   f = {b[DATA_W-2:0], 1'b0};
      default:  f = a;
    endcase
  end

  assign z = (f == '0);
  assign n = f[DATA_W-1];

endmodule

// File: rtl/dp_core.sv
// mycpu datapath: PC, instruction register, 8x16 register file, function
// unit and the shared memory/IO bus drive.
// Optional build macro DP_FLAG_REG_EN: when defined, Z/N are registered and
// only track ALU results written back; otherwise they follow F combinationally.
module dp_core
  import mycpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          NREGS    = 8
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        il_in,
  input  logic [1:0]  ps_in,
  input  logic        rw_in,
  input  logic [11:0] rs_in,
  input  logic        mm_in,
  input  logic [1:0]  md_in,
  input  logic        mb_in,
  input  logic [3:0]  fs_in,
  input  logic        wen_in,
  input  logic        iom_in,
  input  logic [15:0] mem_rdata_in,
  input  logic [15:0] io_rdata_in,
  output logic [15:0] ins_out,
  output logic        z_out,
  output logic        n_out,
  output logic [15:0] addr_out,
  output logic [15:0] wdata_out,
  output logic        mem_we_out,
  output logic        io_we_out
);

  ctrl_word_t cw;

  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] regs_q [NREGS];
  logic [15:0] regs_d [NREGS];

  logic [15:0] a_bus, b_mux, f_bus, d_bus;
  logic        fu_z, fu_n;
  logic signed [5:0] br_off;

  // Bit 3 of each 4-bit register select field carries no meaning
  logic unused_rs;
  assign unused_rs = ^{cw.rs[11], cw.rs[7], cw.rs[3]};

  // Gather the control inputs into one control word
  always_comb begin
    cw     = '0;
    cw.il  = il_in;
    cw.ps  = ps_in;
    cw.rw  = rw_in;
    cw.rs  = rs_in;
    cw.mm  = mm_in;
    cw.md  = md_in;
    cw.mb  = mb_in;
    cw.fs  = fs_t'(fs_in);
    cw.wen = wen_in;
    cw.iom = iom_in;
  end

  // Operand buses: A from the register file, B from register or IR constant
  always_comb begin
    a_bus = regs_q[cw.rs[6:4]];
    b_mux = cw.mb ? {13'b0, ir_q[2:0]} : regs_q[cw.rs[2:0]];
  end

  dp_fu u_fu (
    .a  (a_bus),
    .b  (b_mux),
    .fs (cw.fs),
    .f  (f_bus),
    .z  (fu_z),
    .n  (fu_n)
  );

  // Write-back source select
  always_comb begin
    d_bus = f_bus;
    case (cw.md)
      MD_F:    d_bus = f_bus;
      MD_B:    d_bus = b_mux;
      MD_IO:   d_bus = io_rdata_in;
      MD_MEM:  d_bus = mem_rdata_in;
      default: d_bus = f_bus;
    endcase
  end

  // Bus drive; the two write strobes are mutually exclusive by construction
  always_comb begin
    addr_out   = cw.mm ? a_bus : pc_q;
    wdata_out  = b_mux;
    mem_we_out = ~cw.wen & ~cw.iom;
    io_we_out  = ~cw.wen &  cw.iom;
    ins_out    = ir_q;
  end

  // Next-state for register file, IR and PC; branch offset is {IR[8:6],IR[2:0]}
  always_comb begin
    regs_d = regs_q;
    if (cw.rw) regs_d[cw.rs[10:8]] = d_bus;

    ir_d = cw.il ? mem_rdata_in : ir_q;

    br_off = {ir_q[8:6], ir_q[2:0]};
    pc_d   = pc_q;
    case (cw.ps)
      PS_HOLD: pc_d = pc_q;
      PS_INC:  pc_d = pc_q + 16'd1;
      PS_BR:   pc_d = pc_q + {{10{br_off[5]}}, br_off};
      PS_JMP:  pc_d = a_bus;
      default: pc_d = pc_q;
    endcase
  end

  // Architectural state; reset suppresses every write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      regs_q <= regs_d;
    end
  end

`ifdef DP_FLAG_REG_EN
  logic z_q, z_d, n_q, n_d;
  logic unused_fu_flags;
  assign unused_fu_flags = fu_z ^ fu_n;

  // Flags capture only ALU results that are written back
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    if (cw.rw && (cw.md == MD_F)) begin
      z_d = (d_bus == '0);
      n_d = d_bus[15];
    end
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign z_out = z_q;
  assign n_out = n_q;
`else
  assign z_out = fu_z;
  assign n_out = fu_n;
`endif

endmodule
